// File: rtl/pseudo_spi_in_intf_if.sv
// Bus bundle for pseudo_spi_in_intf: CPU control, scan-chain serial pins and the SRAM write port.
// master = controller/testbench side, slave = the capture block.
interface pseudo_spi_in_intf_if #(
   parameter int unsigned MEMORY_DATA_WIDTH = 8,
   parameter int unsigned MEMORY_ADDR_WIDTH = 9,
   parameter int unsigned RESERVED_DATA_LEN = 8
);
   logic                         BGN;
   logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
   logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
   logic                         SPI_SI;
   logic                         SCLK1;
   logic                         SCLK2;
   logic                         SEL;
   logic [MEMORY_ADDR_WIDTH-1:0] A;
   logic                         CEN;
   logic                         D_WE;
   logic [MEMORY_DATA_WIDTH-1:0] PO;
   logic                         spi_is_done;

   modport master (
      output BGN, ADDR_BGN, DATA_LEN, SPI_SI,
      input  SCLK1, SCLK2, SEL, A, CEN, D_WE, PO, spi_is_done
   );

   modport slave (
      input  BGN, ADDR_BGN, DATA_LEN, SPI_SI,
      output SCLK1, SCLK2, SEL, A, CEN, D_WE, PO, spi_is_done
   );
endinterface

// File: rtl/pseudo_spi_in_intf.sv
// Scan-chain readback: SEL parallel load, two-phase SCLK1/SCLK2 shift-out, bytes written to SRAM
// at a decrementing address. Optional build macro SPI_IN_MSB_FIRST_EN stores the first bit at the MSB.
module pseudo_spi_in_intf #(
   parameter int unsigned MEMORY_DATA_WIDTH = 8,
   parameter int unsigned MEMORY_ADDR_WIDTH = 9,
   parameter int unsigned RESERVED_DATA_LEN = 8
) (
   input logic                 CLK,
   input logic                 RST_N,
   pseudo_spi_in_intf_if.slave bus
);
   localparam int unsigned DW  = MEMORY_DATA_WIDTH;
   localparam int unsigned AW  = MEMORY_ADDR_WIDTH;
   localparam int unsigned LW  = RESERVED_DATA_LEN;
   localparam int unsigned BCW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT, S_WRITE, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     slot_q, slot_d;
   logic [BCW-1:0] bit_q, bit_d;
   logic [1:0]     load_q, load_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [LW-1:0]  word_q, word_d;
   logic [DW-1:0]  shift_q, shift_d;
   logic           sclk1_q, sclk1_d;
   logic           sclk2_q, sclk2_d;
   logic           sel_q, sel_d;
   logic           done_q, done_d;
   logic           cen_q;
   logic           we_q;
   logic [AW-1:0]  a_q;
   logic [DW-1:0]  po_q;

   // State and datapath registers; strobes are registered from next-state so they never glitch
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
         bit_q   <= '0;
         load_q  <= '0;
         addr_q  <= '0;
         word_q  <= '0;
         shift_q <= '0;
         sclk1_q <= 1'b0;
         sclk2_q <= 1'b0;
         sel_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         bit_q   <= bit_d;
         load_q  <= load_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         shift_q <= shift_d;
         sclk1_q <= sclk1_d;
         sclk2_q <= sclk2_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
      end
   end

   // Next-state, counters and strobe decode
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      bit_d   = bit_q;
      load_d  = load_q;
      addr_d  = addr_q;
      word_d  = word_q;
      shift_d = shift_q;

      case (state_q)
         S_IDLE: begin
            addr_d = bus.ADDR_BGN;
            word_d = bus.DATA_LEN;
            load_d = '0;
            slot_d = '0;
            bit_d  = BCW'(DW - 1);
            if (bus.BGN) state_d = (bus.DATA_LEN != '0) ? S_LOAD : S_DONE;
         end
         S_LOAD: begin
            if (load_q == 2'd3) begin
               state_d = S_BIT;
               slot_d  = '0;
               bit_d   = BCW'(DW - 1);
            end else begin
               load_d = load_q + 2'd1;
            end
         end
         S_BIT: begin
`ifdef SPI_IN_MSB_FIRST_EN
            if (slot_q == 3'd0) shift_d = {shift_q[DW-2:0], bus.SPI_SI};
`else
            if (slot_q == 3'd0) shift_d = {bus.SPI_SI, shift_q[DW-1:1]};
`endif
            if (slot_q == 3'd5) begin
               slot_d = '0;
               if (bit_q != '0) bit_d = bit_q - BCW'(1);
               else             state_d = S_WRITE;
            end else begin
               slot_d = slot_q + 3'd1;
            end
         end
         S_WRITE: begin
            addr_d  = addr_q - AW'(1);
            word_d  = word_q - LW'(1);
            slot_d  = '0;
            bit_d   = BCW'(DW - 1);
            state_d = (word_q != LW'(1)) ? S_BIT : S_DONE;
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      // Dropping BGN aborts from any active state
      if (state_q != S_IDLE && !bus.BGN) state_d = S_IDLE;

      sclk1_d = (state_d == S_BIT) && (slot_d == 3'd2);
      sclk2_d = (state_d == S_BIT) && (slot_d == 3'd4);
      sel_d   = (state_d == S_LOAD);
      done_d  = (state_d == S_DONE);
   end

   // SRAM port launched on the falling edge so A/PO/CEN are settled at the capturing rising edge
   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cen_q <= 1'b1;
         we_q  <= 1'b1;
         a_q   <= '0;
         po_q  <= '0;
      end else if (state_q == S_WRITE) begin
         cen_q <= 1'b0;
         we_q  <= 1'b0;
         a_q   <= addr_q;
         po_q  <= shift_q;
      end else begin
         cen_q <= 1'b1;
         we_q  <= 1'b1;
         a_q   <= '0;
      end
   end

   assign bus.SCLK1       = sclk1_q;
   assign bus.SCLK2       = sclk2_q;
   assign bus.SEL         = sel_q;
   assign bus.spi_is_done = done_q;
   assign bus.CEN         = cen_q;
   assign bus.D_WE        = we_q;
   assign bus.A           = a_q;
   assign bus.PO          = po_q;
endmodule
